multicycle_datapath: RTL



---
 rtl/mc_pkg.sv | 67 ++++++
 rtl/alu.sv | 29 ++
 rtl/mc_control.sv | 141 ++++++++++++++
 rtl/regfile32.sv | 31 +++
 rtl/multicycle_datapath.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset datapath.
// Contents: instruction width, opcode/funct constants, FSM state encoding,
// PC source select, ALU control codes, and decode helper functions.
package mc_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_JUMP   = 2'd1,
    PC_TARGET = 2'd2
  } pc_src_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_cntl_e;

  function automatic alu_cntl_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_NOR:   return ALU_NOR;
      F_SLT:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic op_supported(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return funct inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW, OP_HALT: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU shared with the single-cycle datapath.
// Ports: a_i, b_i operands; cntl_i operation; result_o result (wraps at 32 bits);
// zero_o set when result_o is zero. slt compares signed.
module alu
  import mc_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_cntl_e   cntl_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    // NOTE: default assignment before the case so every path drives result_o and no latch is inferred.
    result_o = a_i + b_i;
    case (cntl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLT: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_NOR: result_o = ~(a_i | b_i);
      default: ;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM. State, halted and illegal are registered; datapath
// strobes decode from the current state, the latched opcode/funct and ALU zero.
// Ports: clk_i, rst_i (async, active-high), run_i (0 = hold); op_i/funct_i from IR;
// zero_i from ALU; state_o/halted_o/illegal_o status; remaining outputs are strobes.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output state_e     state_o,
  output logic       halted_o,
  output logic       illegal_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output pc_src_e    pc_src_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,      // 1 = rd, 0 = rt
  output logic       mem_to_reg_o,   // 1 = MDR, 0 = ALUOut
  output logic       mem_write_o,
  output logic       alu_out_write_o,
  output alu_cntl_e  alu_cntl_o,
  output logic       alu_src_b_o,    // 1 = sign-extended immediate, 0 = B
  output logic       retire_o
);

  state_e state_q;
  logic   halted_q;
  logic   illegal_q;
  logic   supported;
  logic   pc_write_c;
  logic   take_branch;

  assign supported = op_supported(op_i, funct_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (run_i) begin
      illegal_q <= (state_q == S_DECODE) && !supported;
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          if (!supported || op_i == OP_J) begin
            state_q <= S_FETCH;
          end else if (op_i == OP_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_i)
            OP_LW, OP_SW:   state_q <= S_MEM;
            OP_BEQ, OP_BNE: state_q <= S_FETCH;
            default:        state_q <= S_WB;
          endcase
        end
        S_MEM:   state_q <= (op_i == OP_LW) ? S_WB : S_FETCH;
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_write_o      = 1'b0;
    pc_write_c      = 1'b0;
    pc_src_o        = PC_PLUS4;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    mem_write_o     = 1'b0;
    alu_out_write_o = 1'b0;
    alu_cntl_o      = ALU_ADD;
    alu_src_b_o     = 1'b0;
    retire_o        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_o = 1'b1;
        pc_write_c = 1'b1;
      end
      S_DECODE: begin
        if (supported && op_i == OP_J) begin
          pc_write_c = 1'b1;
          pc_src_o   = PC_JUMP;
          retire_o   = 1'b1;
        end else if (supported && op_i == OP_HALT) begin
          retire_o = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_i)
          OP_RTYPE: begin
            alu_cntl_o      = funct_to_alu(funct_i);
            alu_out_write_o = 1'b1;
          end
          OP_BEQ, OP_BNE: begin
            alu_cntl_o = ALU_SUB;
            pc_src_o   = PC_TARGET;
            retire_o   = 1'b1;
          end
          default: begin
            alu_src_b_o     = 1'b1;
            alu_out_write_o = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (op_i == OP_SW) begin
          mem_write_o = 1'b1;
          retire_o    = 1'b1;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (op_i == OP_RTYPE);
        mem_to_reg_o = (op_i == OP_LW);
        retire_o     = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch decision kept outside the strobe block: zero_i depends on alu_cntl_o.
  assign take_branch = (state_q == S_EXEC) &&
                       ((op_i == OP_BEQ && zero_i) || (op_i == OP_BNE && !zero_i));
  assign pc_write_o  = pc_write_c | take_branch;

  assign state_o   = state_q;
  assign halted_o  = halted_q;
  assign illegal_o = illegal_q;

endmodule

// File: rtl/regfile32.sv
// 32 x 32-bit register file, two combinational read ports, one write port.
// Ports: clk_i, rst_i (async, active-high); we_i/wa_i/wd_i write; ra1_i/ra2_i
// read addresses; rd1_o/rd2_o read data. Writes to $0 are discarded.
module regfile32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: this storage array is reset because every register must read 0 after reset; data memory is left unreset so it maps onto plain RAM.
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      // NOTE: non-blocking assignment so all flops sample pre-edge values regardless of block evaluation order.
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = regs_q[ra1_i];
  assign rd2_o = regs_q[ra2_i];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset processor: FETCH/DECODE/EXEC/MEM/WB with IR, A, B,
// ALUOut, MDR and Target latches. Instruction memory is a ROM built from IMEM_INIT
// (word 0 in the low bits); data memory is an internal unreset RAM.
// Ports: clock, Reset (async, active-high), run (0 = stall everything);
// Dout = ALUOut, PC_out = PC, state = FSM state, halted, illegal (one-cycle pulse),
// instr_count = saturating retired-instruction count.
module multicycle_datapath
  import mc_pkg::*;
#(
  parameter int                            IMEM_WORDS = 64,
  parameter int                            DMEM_WORDS = 64,
  parameter logic [31:0]                   RESET_PC   = 32'h0000_0000,
  parameter int                            CNT_W      = 16,
  parameter logic [IMEM_WORDS*INSTR_W-1:0] IMEM_INIT  = '0
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             run,
  output logic [31:0]      Dout,
  output logic [31:0]      PC_out,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [31:0]      pc_q, pc_d, ir_q, a_q, b_q, alu_out_q, mdr_q, target_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      imem [IMEM_WORDS];
  logic [31:0]      dmem_q [DMEM_WORDS];
  logic [IA_W-1:0]  imem_idx;
  logic [DA_W-1:0]  dmem_idx;
  logic [31:0]      imm_sext, alu_b, alu_res, rf_rd1, rf_rd2, rf_wd;
  logic [4:0]       rf_wa;
  logic             alu_zero;
  logic             unused_shamt;

  state_e    state_w;
  pc_src_e   pc_src;
  alu_cntl_e alu_cntl;
  logic      ir_write, pc_write, reg_write, reg_dst, mem_to_reg, mem_write;
  logic      alu_out_write, alu_src_b, retire;

  always_comb begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = IMEM_INIT[i*INSTR_W +: INSTR_W];
  end

  // Byte-address bits [1:0] are dropped; upper bits wrap modulo the memory depth.
  assign imem_idx     = pc_q[IA_W+1:2];
  assign dmem_idx     = alu_out_q[DA_W+1:2];
  assign imm_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign alu_b        = alu_src_b ? imm_sext : b_q;
  assign rf_wa        = reg_dst ? ir_q[15:11] : ir_q[20:16];
  assign rf_wd        = mem_to_reg ? mdr_q : alu_out_q;
  assign unused_shamt = ^ir_q[10:6];

  always_comb begin
    pc_d = pc_q + 32'd4;
    case (pc_src)
      PC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      PC_TARGET: pc_d = target_q;
      default:   ;
    endcase
  end

  mc_control u_ctrl (
    .clk_i           (clock),
    .rst_i           (Reset),
    .run_i           (run),
    .op_i            (ir_q[31:26]),
    .funct_i         (ir_q[5:0]),
    .zero_i          (alu_zero),
    .state_o         (state_w),
    .halted_o        (halted),
    .illegal_o       (illegal),
    .ir_write_o      (ir_write),
    .pc_write_o      (pc_write),
    .pc_src_o        (pc_src),
    .reg_write_o     (reg_write),
    .reg_dst_o       (reg_dst),
    .mem_to_reg_o    (mem_to_reg),
    .mem_write_o     (mem_write),
    .alu_out_write_o (alu_out_write),
    .alu_cntl_o      (alu_cntl),
    .alu_src_b_o     (alu_src_b),
    .retire_o        (retire)
  );

  alu u_alu (
    .a_i      (a_q),
    .b_i      (alu_b),
    .cntl_i   (alu_cntl),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  regfile32 u_rf (
    .clk_i (clock),
    .rst_i (Reset),
    .we_i  (reg_write && run),
    .ra1_i (ir_q[25:21]),
    .ra2_i (ir_q[20:16]),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2)
  );

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
    end else if (run) begin
      if (ir_write) ir_q <= imem[imem_idx];
      if (pc_write) pc_q <= pc_d;
      if (state_w == S_DECODE) begin
        a_q      <= rf_rd1;
        b_q      <= rf_rd2;
        // pc_q already holds PC+4 here.
        target_q <= pc_q + {imm_sext[29:0], 2'b00};
      end
      if (alu_out_write)    alu_out_q <= alu_res;
      if (state_w == S_MEM) mdr_q     <= dmem_q[dmem_idx];
      if (retire && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (run && mem_write) dmem_q[dmem_idx] <= b_q;
  end

  assign Dout        = alu_out_q;
  assign PC_out      = pc_q;
  assign state       = state_w;
  assign instr_count = cnt_q;

endmodule
